soc_ext_int_ctrl: RTL and testbench

Parametrised external interrupt controller for FPGA top levels. It replaces the tied-off cpu_int_external / cpu_int_ext_cause stubs with NUM_IRQ real interrupt inputs. Each input is synchronised, then qualified per channel by enable, trigger mode and polarity. Pending channels are arbitrated into a single CPU interrupt line plus a cause code, and all control state is exposed on a small word-addressed register bus.

---
 rtl/soc_ext_int_ctrl_if.sv | 31 +++
 rtl/soc_ext_int_ctrl.sv | 156 +++++++++++++++
 tb/tb_soc_ext_int_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_ext_int_ctrl_if.sv
// soc_ext_int_ctrl_if
// Word-addressed register bus between a CPU-side master and the external
// interrupt controller.
//   bus_req   : register access request (master -> slave)
//   bus_wen   : 1 = write, 0 = read (master -> slave)
//   bus_addr  : byte address of the register (master -> slave)
//   bus_wdata : write data (master -> slave)
//   bus_gnt   : request accepted, combinational (slave -> master)
//   bus_recv  : one-cycle response strobe (slave -> master)
//   bus_rdata : read data, valid with bus_recv (slave -> master)
//   bus_error : error response, valid with bus_recv (slave -> master)
interface soc_ext_int_ctrl_if;
   logic        bus_req;
   logic        bus_wen;
   logic [3:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_gnt;
   logic        bus_recv;
   logic [31:0] bus_rdata;
   logic        bus_error;

   modport master (
      output bus_req, bus_wen, bus_addr, bus_wdata,
      input  bus_gnt, bus_recv, bus_rdata, bus_error
   );

   modport slave (
      input  bus_req, bus_wen, bus_addr, bus_wdata,
      output bus_gnt, bus_recv, bus_rdata, bus_error
   );
endinterface

// File: rtl/soc_ext_int_ctrl.sv
// soc_ext_int_ctrl
// External interrupt controller: NUM_IRQ asynchronous inputs are
// synchronised, qualified per channel by polarity and trigger mode
// (edge / level), latched into PENDING, masked by ENABLE and arbitrated
// (channel 0 highest priority) into one CPU interrupt plus a cause code.
// Register map (word addressed, bits >= NUM_IRQ read 0):
//   0x0 ENABLE (rw), 0x4 MODE (rw, 1 = edge), 0x8 PENDING (r / w1c),
//   0xC POLARITY (rw, 1 = active low)
// Ports:
//   g_clk, g_resetn   : clock, synchronous active-low reset
//   irq_in            : asynchronous interrupt sources
//   bus               : register bus (slave side)
//   cpu_int_external  : registered interrupt request to the CPU
//   cpu_int_ext_cause : registered index of the winning channel
module soc_ext_int_ctrl #(
   parameter int unsigned NUM_IRQ     = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CAUSE_W     = 4
) (
   input  logic                  g_clk,
   input  logic                  g_resetn,
   input  logic [NUM_IRQ-1:0]    irq_in,
   soc_ext_int_ctrl_if.slave     bus,
   output logic                  cpu_int_external,
   output logic [CAUSE_W-1:0]    cpu_int_ext_cause
);

   typedef enum logic [1:0] {
      REG_ENABLE   = 2'd0,
      REG_MODE     = 2'd1,
      REG_PENDING  = 2'd2,
      REG_POLARITY = 2'd3
   } reg_sel_e;

   logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
   logic [NUM_IRQ-1:0] active;
   logic [NUM_IRQ-1:0] hist_q;
   logic [NUM_IRQ-1:0] rise_q;
   logic [NUM_IRQ-1:0] enable_q;
   logic [NUM_IRQ-1:0] mode_q;
   logic [NUM_IRQ-1:0] pending_q;
   logic [NUM_IRQ-1:0] polarity_q;
   logic [NUM_IRQ-1:0] pending_d;
   logic [NUM_IRQ-1:0] clear_mask;
   logic [NUM_IRQ-1:0] masked;
   logic [CAUSE_W-1:0] cause_d;
   logic               cause_found;

   logic               accept;
   logic               aligned;
   logic               wr_ok;
   reg_sel_e           sel;
   logic [31:0]        rd_val;
   logic               recv_q;
   logic               error_q;
   logic [31:0]        rdata_q;
   logic               unused_wdata;

   assign sel     = reg_sel_e'(bus.bus_addr[3:2]);
   assign accept  = bus.bus_req & g_resetn;
   assign aligned = (bus.bus_addr[1:0] == 2'b00);
   assign wr_ok   = accept & bus.bus_wen & aligned;

   assign active  = sync_q[SYNC_STAGES-1] ^ polarity_q;
   assign masked  = pending_q & enable_q;

   assign clear_mask = (wr_ok && sel == REG_PENDING) ? bus.bus_wdata[NUM_IRQ-1:0] : '0;

   // Edge channels: the rise is registered once before it reaches PENDING,
   // so an edge lands SYNC_STAGES+1 edges after first sampling. A rise
   // arriving together with a w1c clear wins. Level channels follow the
   // qualified input directly.
   assign pending_d = (mode_q & ((pending_q & ~clear_mask) | rise_q))
                    | (~mode_q & active);

   assign unused_wdata = ^bus.bus_wdata[31:NUM_IRQ];

   // Read mux; unimplemented upper bits stay 0.
   always_comb begin
      rd_val = '0;
      case (sel)
         REG_ENABLE:   rd_val[NUM_IRQ-1:0] = enable_q;
         REG_MODE:     rd_val[NUM_IRQ-1:0] = mode_q;
         REG_PENDING:  rd_val[NUM_IRQ-1:0] = pending_q;
         REG_POLARITY: rd_val[NUM_IRQ-1:0] = polarity_q;
         default:      rd_val = '0;
      endcase
   end

   // Fixed priority: lowest-numbered masked channel wins.
   always_comb begin
      cause_d     = '0;
      cause_found = 1'b0;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         if (masked[i] && !cause_found) begin
            cause_d     = CAUSE_W'(i);
            cause_found = 1'b1;
         end
      end
   end

   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
      end else begin
         sync_q[0] <= irq_in;
         for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         hist_q            <= '0;
         rise_q            <= '0;
         enable_q          <= '0;
         mode_q            <= '0;
         pending_q         <= '0;
         polarity_q        <= '0;
         cpu_int_external  <= 1'b0;
         cpu_int_ext_cause <= '0;
         recv_q            <= 1'b0;
         error_q           <= 1'b0;
         rdata_q           <= '0;
      end else begin
         hist_q    <= active;
         rise_q    <= active & ~hist_q;
         pending_q <= pending_d;

         if (wr_ok) begin
            case (sel)
               REG_ENABLE:   enable_q   <= bus.bus_wdata[NUM_IRQ-1:0];
               REG_MODE:     mode_q     <= bus.bus_wdata[NUM_IRQ-1:0];
               REG_POLARITY: polarity_q <= bus.bus_wdata[NUM_IRQ-1:0];
               default:      ;
            endcase
         end

         cpu_int_external  <= |masked;
         cpu_int_ext_cause <= cause_d;

         recv_q  <= accept;
         error_q <= accept & ~aligned;
         rdata_q <= (accept && !bus.bus_wen && aligned) ? rd_val : '0;
      end
   end

   assign bus.bus_gnt   = g_resetn;
   assign bus.bus_recv  = recv_q;
   assign bus.bus_rdata = rdata_q;
   assign bus.bus_error = error_q;

endmodule

// File: tb/tb_soc_ext_int_ctrl.sv
// tb_soc_ext_int_ctrl
// Self-checking bench for soc_ext_int_ctrl (NUM_IRQ=8, SYNC_STAGES=2,
// CAUSE_W=4). A cycle-level behavioural model derived from the register
// and interrupt rules predicts every output each cycle; directed scenarios
// add literal expectations, followed by a randomized phase.
module tb_soc_ext_int_ctrl;
   localparam int N  = 8;
   localparam int S  = 2;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  irq;
   logic          cpu_int;
   logic [CW-1:0] cause;

   soc_ext_int_ctrl_if bus_if ();

   soc_ext_int_ctrl #(
      .NUM_IRQ     (N),
      .SYNC_STAGES (S),
      .CAUSE_W     (CW)
   ) dut (
      .g_clk             (clk),
      .g_resetn          (rst_n),
      .irq_in            (irq),
      .bus               (bus_if),
      .cpu_int_external  (cpu_int),
      .cpu_int_ext_cause (cause)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [N-1:0]  m_en, m_mode, m_pend, m_pol;
   logic [N-1:0]  m_a1, m_a2;          // qualified input one and two cycles back
   logic [N-1:0]  irq_q [$];           // raw samples still travelling through the synchroniser
   logic          e_int, e_recv, e_err;
   logic [CW-1:0] e_cause;
   logic [31:0]   e_rdata;
   logic          chk = 1'b0;

   always @(posedge clk) begin : model
      logic [N-1:0] s_v, a_v, rise_v, clr_v, pnew, msk;
      logic [31:0]  rv;
      logic         al;
      if (!rst_n) begin
         m_en = '0; m_mode = '0; m_pend = '0; m_pol = '0;
         m_a1 = '0; m_a2 = '0;
         irq_q.delete();
         for (int k = 0; k < S; k++) irq_q.push_back('0);
         e_int = 0; e_cause = '0; e_recv = 0; e_err = 0; e_rdata = '0;
         chk = 1'b1;
      end else if (chk) begin
         s_v = irq_q.pop_front();
         irq_q.push_back(irq);
         a_v    = s_v ^ m_pol;
         rise_v = m_a1 & ~m_a2;

         msk     = m_pend & m_en;
         e_int   = (msk != '0);
         e_cause = '0;
         for (int i = N - 1; i >= 0; i--) if (msk[i]) e_cause = CW'(i);

         al = (bus_if.bus_addr[1:0] == 2'b00);
         case (bus_if.bus_addr[3:2])
            2'd0:    rv = 32'(m_en);
            2'd1:    rv = 32'(m_mode);
            2'd2:    rv = 32'(m_pend);
            default: rv = 32'(m_pol);
         endcase
         e_recv  = bus_if.bus_req;
         e_err   = bus_if.bus_req && !al;
         e_rdata = (bus_if.bus_req && !bus_if.bus_wen && al) ? rv : 32'h0;

         clr_v = '0;
         if (bus_if.bus_req && bus_if.bus_wen && al && bus_if.bus_addr[3:2] == 2'd2)
            clr_v = bus_if.bus_wdata[N-1:0];
         for (int i = 0; i < N; i++)
            pnew[i] = m_mode[i] ? ((m_pend[i] & ~clr_v[i]) | rise_v[i]) : a_v[i];

         if (bus_if.bus_req && bus_if.bus_wen && al) begin
            case (bus_if.bus_addr[3:2])
               2'd0:    m_en   = bus_if.bus_wdata[N-1:0];
               2'd1:    m_mode = bus_if.bus_wdata[N-1:0];
               2'd3:    m_pol  = bus_if.bus_wdata[N-1:0];
               default: ;
            endcase
         end
         m_pend = pnew;
         m_a2   = m_a1;
         m_a1   = a_v;
      end
      #1;
      if (chk) begin
         check("int",   32'(cpu_int),          32'(e_int));
         check("cause", 32'(cause),            32'(e_cause));
         check("recv",  32'(bus_if.bus_recv),  32'(e_recv));
         check("rdata", bus_if.bus_rdata,      e_rdata);
         check("error", 32'(bus_if.bus_error), 32'(e_err));
         check("gnt",   32'(bus_if.bus_gnt),   32'(rst_n));
      end
   end

   // ---------------- bus tasks ----------------
   task automatic bus_write(input logic [3:0] ad, input logic [31:0] d, output logic er);
      @(negedge clk);
      bus_if.bus_req = 1'b1; bus_if.bus_wen = 1'b1;
      bus_if.bus_addr = ad;  bus_if.bus_wdata = d;
      @(negedge clk);
      bus_if.bus_req = 1'b0; bus_if.bus_wen = 1'b0;
      check("wr_recv", 32'(bus_if.bus_recv), 32'd1);
      er = bus_if.bus_error;
   endtask

   task automatic bus_read(input logic [3:0] ad, output logic [31:0] d, output logic er);
      @(negedge clk);
      bus_if.bus_req = 1'b1; bus_if.bus_wen = 1'b0; bus_if.bus_addr = ad;
      @(negedge clk);
      bus_if.bus_req = 1'b0;
      check("rd_recv", 32'(bus_if.bus_recv), 32'd1);
      d  = bus_if.bus_rdata;
      er = bus_if.bus_error;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] d;
      logic        er;
      int          first;

      rst_n = 1'b0; irq = '0;
      bus_if.bus_req = 1'b0; bus_if.bus_wen = 1'b0;
      bus_if.bus_addr = '0;  bus_if.bus_wdata = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // 1: idle after reset, all registers read 0
      idle(10);
      check("t1_int",   32'(cpu_int), 32'd0);
      check("t1_cause", 32'(cause),   32'd0);
      for (int k = 0; k < 4; k++) begin
         bus_read(4'(k * 4), d, er);
         check("t1_rdata", d, 32'd0);
         check("t1_err",   32'(er), 32'd0);
      end

      // 2: edge channel 3, one-cycle pulse, latency and w1c
      bus_write(4'h0, 32'h08, er);
      bus_write(4'h4, 32'h08, er);
      @(negedge clk);
      irq[3] = 1'b1;
      first = -1;
      for (int e = 0; e < 10; e++) begin
         @(negedge clk);
         if (e == 0) irq[3] = 1'b0;
         if (first < 0 && cpu_int) first = e;
      end
      check("t2_latency", 32'(first), 32'd4);
      check("t2_cause",   32'(cause), 32'd3);
      bus_read(4'h8, d, er);
      check("t2_pend", d, 32'h08);
      bus_write(4'h8, 32'h08, er);
      check("t2_int_hold", 32'(cpu_int), 32'd1);
      @(negedge clk);
      check("t2_int_fall", 32'(cpu_int), 32'd0);

      // 3: level mode priority, w1c ignored
      bus_write(4'h4, 32'h00, er);
      bus_write(4'h0, 32'hFF, er);
      irq = 8'h24;
      idle(6);
      check("t3_cause2", 32'(cause),   32'd2);
      check("t3_int",    32'(cpu_int), 32'd1);
      irq = 8'h20;
      idle(4);
      check("t3_cause5", 32'(cause), 32'd5);
      bus_write(4'h8, 32'hFF, er);
      bus_read(4'h8, d, er);
      check("t3_pend", d, 32'h20);

      // 4: rise and w1c hit PENDING[1] on the same edge
      irq = '0;
      bus_write(4'h4, 32'h02, er);
      idle(4);
      irq[1] = 1'b1;
      repeat (3) @(posedge clk);
      bus_write(4'h8, 32'h02, er);
      bus_read(4'h8, d, er);
      check("t4_pend", d, 32'h02);

      // 5: active-low level channel 0
      irq = '0;
      bus_write(4'h4, 32'h00, er);
      bus_write(4'hC, 32'h01, er);
      idle(4);
      bus_read(4'h8, d, er);
      check("t5_pend_set", d, 32'h01);
      irq[0] = 1'b1;
      idle(4);
      bus_read(4'h8, d, er);
      check("t5_pend_clr", d, 32'h00);

      // 6: misaligned accesses, then reset with interrupt and read in flight
      bus_read(4'h6, d, er);
      check("t6_rd_err",   32'(er), 32'd1);
      check("t6_rd_data",  d,       32'd0);
      bus_write(4'h2, 32'h00, er);
      check("t6_wr_err",   32'(er), 32'd1);
      bus_read(4'h0, d, er);
      check("t6_enable",   d,       32'hFF);
      bus_write(4'hC, 32'h00, er);
      irq = 8'h10;
      idle(5);
      check("t6_int",   32'(cpu_int), 32'd1);
      check("t6_cause", 32'(cause),   32'd4);
      bus_if.bus_req = 1'b1; bus_if.bus_wen = 1'b0; bus_if.bus_addr = 4'h8;
      @(negedge clk);
      bus_if.bus_req = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      check("t6_rst_int",   32'(cpu_int),          32'd0);
      check("t6_rst_cause", 32'(cause),            32'd0);
      check("t6_rst_recv",  32'(bus_if.bus_recv),  32'd0);
      check("t6_rst_rdata", bus_if.bus_rdata,      32'd0);
      check("t6_rst_err",   32'(bus_if.bus_error), 32'd0);
      check("t6_rst_gnt",   32'(bus_if.bus_gnt),   32'd0);
      rst_n = 1'b1;
      idle(2);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst_n = ($urandom_range(0, 299) != 0);
         irq   = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
         bus_if.bus_req   = ($urandom_range(0, 1) == 1);
         bus_if.bus_wen   = ($urandom_range(0, 1) == 1);
         bus_if.bus_addr  = ($urandom_range(0, 7) == 0) ? 4'($urandom)
                                                        : {2'($urandom), 2'b00};
         bus_if.bus_wdata = $urandom;
      end
      @(negedge clk);
      bus_if.bus_req = 1'b0;
      rst_n = 1'b1;
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
